pipeline_controller: RTL

Control and hazard unit for the 5-stage (F/D/E/M/W) ARM-subset datapath. Decodes InstrD fields in Decode and pipelines the control bundle through E/M/W. Holds the NZCV flags register and evaluates conditional execution in E. Generates forwarding selects, load-use stalls and branch/PC-write flushes for the datapath pipeline registers.

---
 rtl/pipeline_controller.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_controller.sv
// pipeline_controller: ARM-subset decode, NZCV flags and conditional execution,
// plus forwarding/stall/flush control for a 5-stage F/D/E/M/W pipeline.
module pipeline_controller #(
    parameter int RA_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      CondD,
    input  logic [1:0]      OpD,
    input  logic [5:0]      FunctD,
    input  logic [RA_W-1:0] RdD,
    input  logic [RA_W-1:0] RA1D,
    input  logic [RA_W-1:0] RA2D,
    input  logic [RA_W-1:0] WA3E,
    input  logic [RA_W-1:0] WA3M,
    input  logic [RA_W-1:0] WA3W,
    input  logic [3:0]      ALUFlags,
    output logic [1:0]      RegSrcD,
    output logic [1:0]      ImmSrcD,
    output logic            ALUSrcE,
    output logic [1:0]      ALUControlE,
    output logic            MemWriteM,
    output logic            RegWriteW,
    output logic            MemtoRegW,
    output logic            PCSrcW,
    output logic            BranchTakenE,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic            FlushE
);
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_ctl;
        logic [1:0] flag_write;
        logic [3:0] cond;
        logic       pcs;
    } ctl_t;

    // A bubble carries condition AL so it never looks like a failed conditional
    localparam ctl_t CTL_IDLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1110, 1'b0};

    ctl_t            ctl_d, ctl_e_d, ctl_e_q;
    logic [RA_W-1:0] ra1_e_d, ra2_e_d, ra1_e_q, ra2_e_q;
    logic [3:0]      flags_d, flags_q;
    logic            reg_write_m_q, mem_write_m_q, mem_to_reg_m_q, pcs_m_q;
    logic            reg_write_w_q, mem_to_reg_w_q, pcs_w_q;
    logic [3:0]      cmd;
    logic            s_eff, cond_ex_e, ldr_stall, pc_wr_pend;
    logic            n, z, c, v;

    assign cmd   = FunctD[4:1];
    assign s_eff = FunctD[0] | (cmd == 4'b1010);

    always_comb begin
        ctl_d      = CTL_IDLE;
        ctl_d.cond = CondD;
        RegSrcD    = 2'b00;
        ImmSrcD    = 2'b00;
        case (OpD)
            2'b00: begin
                ctl_d.alu_src    = FunctD[5];
                ctl_d.flag_write = {s_eff, s_eff & (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010)};
                case (cmd)
                    4'b0100: ctl_d.reg_write = 1'b1;
                    4'b0010: begin ctl_d.alu_ctl = 2'b01; ctl_d.reg_write = 1'b1; end
                    4'b0000: begin ctl_d.alu_ctl = 2'b10; ctl_d.reg_write = 1'b1; end
                    4'b1100: begin ctl_d.alu_ctl = 2'b11; ctl_d.reg_write = 1'b1; end
                    4'b1010: ctl_d.alu_ctl = 2'b01;
                    default: ;
                endcase
            end
            2'b01: begin
                ctl_d.alu_src    = 1'b1;
                ctl_d.mem_to_reg = FunctD[0];
                ctl_d.reg_write  = FunctD[0];
                ctl_d.mem_write  = ~FunctD[0];
                RegSrcD          = {~FunctD[0], 1'b0};
                ImmSrcD          = 2'b01;
            end
            2'b10: begin
                ctl_d.branch  = 1'b1;
                ctl_d.alu_src = 1'b1;
                RegSrcD       = 2'b01;
                ImmSrcD       = 2'b10;
            end
            default: ;
        endcase
        ctl_d.pcs = ctl_d.reg_write & (RdD == RA_W'(15));
    end

    assign {n, z, c, v} = flags_q;

    always_comb begin
        case (ctl_e_q.cond)
            4'b0000: cond_ex_e = z;
            4'b0001: cond_ex_e = ~z;
            4'b0010: cond_ex_e = c;
            4'b0011: cond_ex_e = ~c;
            4'b0100: cond_ex_e = n;
            4'b0101: cond_ex_e = ~n;
            4'b0110: cond_ex_e = v;
            4'b0111: cond_ex_e = ~v;
            4'b1000: cond_ex_e = c & ~z;
            4'b1001: cond_ex_e = ~c | z;
            4'b1010: cond_ex_e = n == v;
            4'b1011: cond_ex_e = n != v;
            4'b1100: cond_ex_e = ~z & (n == v);
            4'b1101: cond_ex_e = z | (n != v);
            4'b1110: cond_ex_e = 1'b1;
            default: cond_ex_e = 1'b0;
        endcase
    end

    assign flags_d = {(ctl_e_q.flag_write[1] & cond_ex_e) ? ALUFlags[3:2] : flags_q[3:2],
                      (ctl_e_q.flag_write[0] & cond_ex_e) ? ALUFlags[1:0] : flags_q[1:0]};

    assign ctl_e_d = FlushE ? CTL_IDLE : ctl_d;
    assign ra1_e_d = FlushE ? '0 : RA1D;
    assign ra2_e_d = FlushE ? '0 : RA2D;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_e_q        <= CTL_IDLE;
            ra1_e_q        <= '0;
            ra2_e_q        <= '0;
            flags_q        <= 4'b0000;
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            pcs_m_q        <= 1'b0;
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
            pcs_w_q        <= 1'b0;
        end else begin
            ctl_e_q        <= ctl_e_d;
            ra1_e_q        <= ra1_e_d;
            ra2_e_q        <= ra2_e_d;
            flags_q        <= flags_d;
            reg_write_m_q  <= ctl_e_q.reg_write & cond_ex_e;
            mem_write_m_q  <= ctl_e_q.mem_write & cond_ex_e;
            mem_to_reg_m_q <= ctl_e_q.mem_to_reg;
            pcs_m_q        <= ctl_e_q.pcs & cond_ex_e;
            reg_write_w_q  <= reg_write_m_q;
            mem_to_reg_w_q <= mem_to_reg_m_q;
            pcs_w_q        <= pcs_m_q;
        end
    end

    assign ALUSrcE      = ctl_e_q.alu_src;
    assign ALUControlE  = ctl_e_q.alu_ctl;
    assign MemWriteM    = mem_write_m_q;
    assign RegWriteW    = reg_write_w_q;
    assign MemtoRegW    = mem_to_reg_w_q;
    assign PCSrcW       = pcs_w_q;
    assign BranchTakenE = ctl_e_q.branch & cond_ex_e;

    assign ForwardAE = (reg_write_m_q && ra1_e_q == WA3M) ? 2'b10 :
                       (reg_write_w_q && ra1_e_q == WA3W) ? 2'b01 : 2'b00;
    assign ForwardBE = (reg_write_m_q && ra2_e_q == WA3M) ? 2'b10 :
                       (reg_write_w_q && ra2_e_q == WA3W) ? 2'b01 : 2'b00;

    assign ldr_stall  = ctl_e_q.mem_to_reg & (RA1D == WA3E || RA2D == WA3E);
    assign pc_wr_pend = ctl_d.pcs | ctl_e_q.pcs | pcs_m_q;
    assign StallD     = ldr_stall;
    assign StallF     = ldr_stall | pc_wr_pend;
    assign FlushD     = pc_wr_pend | pcs_w_q | BranchTakenE;
    assign FlushE     = ldr_stall | BranchTakenE;
endmodule
